sos_trigger_module: RTL and testbench

//   Upstream stage for the SOS generator. Synchronises and debounces a raw

---
 rtl/sos_trigger_module.sv | 175 +++++++++++++++++
 tb/tb_sos_trigger_module.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sos_trigger_module.sv
// sos_trigger_module: conditions a raw active-low push-button (two-flop
// synchroniser plus counter debounce), then sequences start requests to the
// SOS generator. One press can be queued while a message is running, and an
// optional auto-repeat mode loops the message with a fixed low gap.
`timescale 1ns/1ps
module sos_trigger_module #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20,
    parameter int GAP_CYCLES      = 50000000,
    parameter int GAP_W           = 26
) (
    input  logic CLK,
    input  logic RST,
    input  logic Key_In,
    input  logic Repeat_En,
    input  logic Done_Sig,
    output logic Start_Sig,
    output logic Busy,
    output logic Pend_Flag,
    output logic Key_Press
);

    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Terminal counts; the counters stop here and never wrap.
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser chain (idles at 1 because the key is active-low)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   k_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = Key_In;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign k_s = sync_reg[SYNC_STAGES-1];

    // Shift the raw key through the synchroniser flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // mismatching samples; any matching sample restarts the count.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_reg;
    logic            key_db_reg;
    logic            key_press_reg;

    // Track mismatch run length, flip the debounced level, pulse on a press edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            db_cnt_reg    <= '0;
            key_db_reg    <= 1'b1;
            key_press_reg <= 1'b0;
        end else begin
            key_press_reg <= 1'b0;
            if (k_s == key_db_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg >= DB_LAST) begin
                key_db_reg    <= k_s;
                db_cnt_reg    <= '0;
                // Only the 1->0 transition of the debounced key is a press.
                key_press_reg <= ~k_s;
            end else begin
                db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Start sequencer
    // ------------------------------------------------------------------
    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             pend_reg;
    logic             pend_next;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_next;
    logic             start_reg;
    logic             busy_reg;

    // Next-state logic for IDLE / RUN / GAP, the pending-press flag and gap timer.
    always_comb begin
        state_next   = state_reg;
        pend_next    = pend_reg;
        gap_cnt_next = gap_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                gap_cnt_next = '0;
                pend_next    = 1'b0;
                if (key_press_reg) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                gap_cnt_next = '0;
                // One-deep queue: a press while pending is simply dropped.
                if (key_press_reg) begin
                    pend_next = 1'b1;
                end
                // A press arriving with Done still counts as queued, so it
                // forces the gap path rather than returning to IDLE.
                if (Done_Sig) begin
                    if (pend_reg || key_press_reg || Repeat_En) begin
                        state_next = ST_GAP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                // Presses are absorbed here: another run is already due.
                if (!Repeat_En && !pend_reg) begin
                    state_next   = ST_IDLE;
                    gap_cnt_next = '0;
                end else if (gap_cnt_reg >= GAP_LAST) begin
                    state_next   = ST_RUN;
                    pend_next    = 1'b0;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: begin
                state_next   = ST_IDLE;
                pend_next    = 1'b0;
                gap_cnt_next = '0;
            end
        endcase
    end

    // Register the FSM and drive Start/Busy straight from flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            pend_reg    <= 1'b0;
            gap_cnt_reg <= '0;
            start_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pend_reg    <= pend_next;
            gap_cnt_reg <= gap_cnt_next;
            start_reg   <= (state_next == ST_RUN);
            busy_reg    <= (state_next != ST_IDLE);
        end
    end

    assign Start_Sig = start_reg;
    assign Busy      = busy_reg;
    assign Pend_Flag = pend_reg;
    assign Key_Press = key_press_reg;

endmodule

// File: tb/tb_sos_trigger_module.sv
// tb_sos_trigger_module: directed scenarios for the SOS trigger stage, with a
// cycle-level reference model compared against the DUT on every cycle and
// literal expectations for the key latencies and gap lengths.
`timescale 1ns/1ps
module tb_sos_trigger_module;

    localparam int DB  = 4;
    localparam int GAP = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Key_In = 1'b1;
    logic Repeat_En = 1'b0;
    logic Done_Sig = 1'b0;
    logic Start_Sig, Busy, Pend_Flag, Key_Press;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    sos_trigger_module #(
        .DEBOUNCE_CYCLES(DB),
        .DB_W(3),
        .GAP_CYCLES(GAP),
        .GAP_W(2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .Key_In(Key_In),
        .Repeat_En(Repeat_En),
        .Done_Sig(Done_Sig),
        .Start_Sig(Start_Sig),
        .Busy(Busy),
        .Pend_Flag(Pend_Flag),
        .Key_Press(Key_Press)
    );

    initial forever #5 CLK = ~CLK;

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %b want %b at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Key acceptance: the last DB synchronised samples
    // (raw samples delayed by two clocks) all disagree with the accepted
    // level. Message flow: running / gap-with-countdown / idle, plus a
    // single queued press.
    // ------------------------------------------------------------------
    bit m_hist [0:DB];   // m_hist[0] = raw key sampled at the previous edge
    bit m_db;
    bit m_press;
    bit m_run;
    bit m_gap;
    bit m_pend;
    int m_gap_left;

    task automatic model_step();
        bit accept;
        bit p;
        if (RST) begin
            for (int i = 0; i <= DB; i++) m_hist[i] = 1'b1;
            m_db = 1'b1;
            m_press = 1'b0;
            m_run = 1'b0;
            m_gap = 1'b0;
            m_pend = 1'b0;
            m_gap_left = 0;
        end else begin
            p = m_press;
            if (m_run) begin
                if (p) m_pend = 1'b1;
                if (Done_Sig) begin
                    m_run = 1'b0;
                    if (m_pend || Repeat_En) begin
                        m_gap = 1'b1;
                        m_gap_left = GAP;
                    end
                end
            end else if (m_gap) begin
                if (!Repeat_En && !m_pend) begin
                    m_gap = 1'b0;
                end else begin
                    m_gap_left--;
                    if (m_gap_left == 0) begin
                        m_gap = 1'b0;
                        m_run = 1'b1;
                        m_pend = 1'b0;
                    end
                end
            end else if (p) begin
                m_run = 1'b1;
            end
            accept = 1'b1;
            for (int i = 1; i <= DB; i++) begin
                if (m_hist[i] == m_db) accept = 1'b0;
            end
            m_press = 1'b0;
            if (accept) begin
                m_db = !m_db;
                m_press = !m_db;
            end
            for (int i = DB; i >= 1; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = Key_In;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            check("model_start", Start_Sig, m_run);
            check("model_busy", Busy, m_run | m_gap);
            check("model_pend", Pend_Flag, m_pend);
            check("model_press", Key_Press, m_press);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic tick_cnt(input int n, inout int c);
        repeat (n) begin
            tick(1);
            if (Key_Press) c++;
        end
    endtask

    task automatic press_key();
        Key_In = 1'b0;
        tick(DB + 4);
        Key_In = 1'b1;
        tick(DB + 4);
    endtask

    task automatic pulse_done();
        Done_Sig = 1'b1;
        tick(1);
        Done_Sig = 1'b0;
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!Start_Sig && n < 20) begin
            n++;
            tick(1);
        end
    endtask

    task automatic count_starts(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            tick(1);
            if (Start_Sig) n++;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int pc;
        int first_press;
        int first_start;
        int hi;
        int low;
        int n;

        // Reset
        RST = 1'b1;
        Key_In = 1'b1;
        tick(2);
        chk_en = 1'b1;
        check("rst_start", Start_Sig, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_pend", Pend_Flag, 1'b0);
        check("rst_press", Key_Press, 1'b0);
        RST = 1'b0;
        tick(2);
        $display("reset: outputs start=%b busy=%b pend=%b press=%b", Start_Sig, Busy, Pend_Flag, Key_Press);

        // Bounce shorter than the debounce window
        pc = 0;
        Key_In = 1'b0; tick_cnt(3, pc);
        Key_In = 1'b1; tick_cnt(1, pc);
        Key_In = 1'b0; tick_cnt(3, pc);
        Key_In = 1'b1; tick_cnt(10, pc);
        check_int("bounce_no_press", pc, 0);
        $display("bounce: presses seen=%0d", pc);

        // Clean press: Key_Press in cycle 6, Start in cycle 7
        pc = 0;
        first_press = -1;
        first_start = -1;
        Key_In = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (Key_Press) begin
                pc++;
                if (first_press < 0) first_press = i;
            end
            if (Start_Sig && first_start < 0) first_start = i;
        end
        Key_In = 1'b1;
        check_int("press_cycle", first_press, 6);
        check_int("press_count", pc, 1);
        check_int("start_cycle", first_start, 7);
        $display("press: key_press cycle=%0d start cycle=%0d", first_press, first_start);

        // Single run held until Done
        hi = 0;
        repeat (20) begin
            tick(1);
            if (Start_Sig) hi++;
        end
        check_int("run_hold", hi, 20);
        pulse_done();
        check("single_done_start", Start_Sig, 1'b0);
        check("single_done_busy", Busy, 1'b0);
        $display("single run: held %0d cycles, start=%b after done", hi, Start_Sig);

        // Done while idle is ignored
        pulse_done();
        tick(2);
        check("idle_done_busy", Busy, 1'b0);

        // Reset mid-run
        press_key();
        check("midrun_start_before", Start_Sig, 1'b1);
        RST = 1'b1;
        tick(1);
        check("midrun_rst_start", Start_Sig, 1'b0);
        check("midrun_rst_busy", Busy, 1'b0);
        RST = 1'b0;
        tick(2);
        $display("reset mid-run: start=%b", Start_Sig);

        // Pending press
        press_key();
        press_key();
        press_key();
        check("pend_set", Pend_Flag, 1'b1);
        tick(2);
        pulse_done();
        count_low(low);
        check_int("pend_gap_low", low, GAP);
        check("pend_rerun_start", Start_Sig, 1'b1);
        check("pend_cleared", Pend_Flag, 1'b0);
        tick(5);
        pulse_done();
        check("pend_final_busy", Busy, 1'b0);
        count_starts(10, n);
        check_int("pend_no_more_runs", n, 0);
        $display("pending: gap low=%0d extra runs after final done=%0d", low, n);

        // Auto-repeat
        Repeat_En = 1'b1;
        press_key();
        for (int r = 0; r < 3; r++) begin
            tick(3);
            pulse_done();
            count_low(low);
            check_int("repeat_gap_low", low, GAP);
            check("repeat_rerun", Start_Sig, 1'b1);
            $display("repeat: run %0d gap low=%0d", r, low);
        end
        tick(2);
        pulse_done();
        tick(1);
        check("repeat_in_gap", Busy, 1'b1);
        Repeat_En = 1'b0;
        tick(1);
        check("repeat_drop_busy", Busy, 1'b0);
        check("repeat_drop_start", Start_Sig, 1'b0);
        count_starts(10, n);
        check_int("repeat_drop_no_runs", n, 0);
        $display("repeat stop: busy=%b later runs=%0d", Busy, n);

        // Press and Done in the same cycle
        press_key();
        Key_In = 1'b0;
        n = 0;
        while (!Key_Press && n < 20) begin
            tick(1);
            n++;
        end
        check("simul_press_seen", Key_Press, 1'b1);
        pulse_done();
        check("simul_gap_start", Start_Sig, 1'b0);
        check("simul_gap_busy", Busy, 1'b1);
        check("simul_gap_pend", Pend_Flag, 1'b1);
        count_low(low);
        check_int("simul_gap_low", low, GAP);
        check("simul_rerun", Start_Sig, 1'b1);
        check("simul_pend_clear", Pend_Flag, 1'b0);
        Key_In = 1'b1;
        tick(10);
        pulse_done();
        check("simul_final_busy", Busy, 1'b0);
        count_starts(10, n);
        check_int("simul_no_more_runs", n, 0);
        $display("simultaneous: gap low=%0d later runs=%0d", low, n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
